// File: rtl/apmu_ibex_pkg.sv
// Shared types for the PMU-enabled core: RF write-port source encoding and
// the PMC starvation-guard state machine.
package apmu_ibex_pkg;

   typedef enum logic [1:0] {
      RF_SRC_NONE,
      RF_SRC_ID,
      RF_SRC_LSU,
      RF_SRC_PMC
   } rf_wr_src_e;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_WAIT,
      ARB_FORCE
   } arb_state_e;

   localparam int unsigned RegAddrW = 5;
   localparam int unsigned RegDataW = 32;

endpackage

// File: rtl/apmu_ibex_pmc_wr_fifo.sv
// PMC write queue: storage, per-entry live bits, pointers and occupancy count,
// squash-by-address, head pop and read-address compare for hazard detection.
module apmu_ibex_pmc_wr_fifo
   import apmu_ibex_pkg::*;
#(
   parameter int unsigned FifoDepth = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic [RegAddrW-1:0]          push_addr_i,
   input  logic [RegDataW-1:0]          push_data_i,
   input  logic                         port_free_i,
   input  logic                         squash_i,
   input  logic [RegAddrW-1:0]          squash_addr_i,
   input  logic [RegAddrW-1:0]          rs1_addr_i,
   input  logic [RegAddrW-1:0]          rs2_addr_i,
   output logic                         head_live_o,
   output logic [RegAddrW-1:0]          head_addr_o,
   output logic [RegDataW-1:0]          head_data_o,
   output logic                         full_o,
   output logic [$clog2(FifoDepth):0]   count_o,
   output logic                         live_any_next_o,
   output logic                         rs_match_o
);

   localparam int unsigned PtrW = $clog2(FifoDepth);

   logic [RegAddrW-1:0]  addr_q [FifoDepth];
   logic [RegDataW-1:0]  data_q [FifoDepth];
   logic [FifoDepth-1:0] live_q, live_d;
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]        count_q;
   logic                 pop;

   assign head_live_o     = live_q[rd_ptr_q];
   assign head_addr_o     = addr_q[rd_ptr_q];
   assign head_data_o     = data_q[rd_ptr_q];
   assign full_o          = (count_q == (PtrW+1)'(FifoDepth));
   assign count_o         = count_q;
   assign live_any_next_o = |live_d;

   // A dead head leaves at once; a live head only when the port is free.
   assign pop = (count_q != '0) && (!head_live_o || port_free_i);

   always_comb begin
      live_d     = live_q;
      rs_match_o = 1'b0;
      for (int i = 0; i < FifoDepth; i++) begin
         if (live_q[i] && ((addr_q[i] == rs1_addr_i) || (addr_q[i] == rs2_addr_i))) begin
            rs_match_o = 1'b1;
         end
         if (squash_i && live_q[i] && (addr_q[i] == squash_addr_i)) begin
            live_d[i] = 1'b0;
         end
      end
      if (pop) live_d[rd_ptr_q] = 1'b0;
      if (push_i) live_d[wr_ptr_q] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         live_q   <= '0;
      end else begin
         live_q <= live_d;
         if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({push_i, pop})
            2'b10:   count_q <= count_q + (PtrW+1)'(1);
            2'b01:   count_q <= count_q - (PtrW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         addr_q[wr_ptr_q] <= push_addr_i;
         data_q[wr_ptr_q] <= push_data_i;
      end
   end

   a_enq_ready: assert property (@(posedge clk_i) disable iff (rst_i) push_i |-> !full_o);

endmodule

// File: rtl/apmu_ibex_rf_wr_arbiter.sv
// RF write-port arbiter (ID > LSU > queued PMC). The optional starvation guard
// that stalls ID/EX to force a PMC slot is enabled by APMU_RF_ARB_STARVE_EN.
module apmu_ibex_rf_wr_arbiter
   import apmu_ibex_pkg::*;
#(
   parameter int unsigned FifoDepth = 2,
   parameter int unsigned MaxStall  = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       id_we_i,
   input  logic [4:0]                 id_waddr_i,
   input  logic [31:0]                id_wdata_i,
   input  logic                       lsu_we_i,
   input  logic [4:0]                 lsu_waddr_i,
   input  logic [31:0]                lsu_wdata_i,
   input  logic                       pmc_valid_i,
   output logic                       pmc_ready_o,
   input  logic [4:0]                 pmc_waddr_i,
   input  logic [31:0]                pmc_wdata_i,
   output logic                       rf_we_o,
   output logic [4:0]                 rf_waddr_o,
   output logic [31:0]                rf_wdata_o,
   output rf_wr_src_e                 rf_wr_src_o,
   input  logic [4:0]                 rs1_addr_i,
   input  logic [4:0]                 rs2_addr_i,
   output logic                       rd_hazard_o,
   output logic                       stall_id_o,
   output logic [$clog2(FifoDepth):0] pmc_pending_o,
   output logic                       collision_err_o
);

   // PMC handshake: a request transfers in any cycle where pmc_valid_i and
   // pmc_ready_o are both high; valid may drop or change only after transfer.
   logic        push, port_free, full, head_live, live_any_next, rs_match;
   logic [4:0]  head_addr;
   logic [31:0] head_data;

   assign port_free   = !id_we_i && !lsu_we_i;
   assign pmc_ready_o = !full;
   assign push        = pmc_valid_i && pmc_ready_o && (pmc_waddr_i != 5'd0);
   assign rd_hazard_o = rs_match ||
                        (push && ((pmc_waddr_i == rs1_addr_i) || (pmc_waddr_i == rs2_addr_i)));

   apmu_ibex_pmc_wr_fifo #(.FifoDepth(FifoDepth)) u_fifo (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .push_i          (push),
      .push_addr_i     (pmc_waddr_i),
      .push_data_i     (pmc_wdata_i),
      .port_free_i     (port_free),
      .squash_i        (id_we_i || lsu_we_i),
      .squash_addr_i   (id_we_i ? id_waddr_i : lsu_waddr_i),
      .rs1_addr_i      (rs1_addr_i),
      .rs2_addr_i      (rs2_addr_i),
      .head_live_o     (head_live),
      .head_addr_o     (head_addr),
      .head_data_o     (head_data),
      .full_o          (full),
      .count_o         (pmc_pending_o),
      .live_any_next_o (live_any_next),
      .rs_match_o      (rs_match)
   );

   always_comb begin
      rf_wr_src_o = RF_SRC_NONE;
      rf_waddr_o  = '0;
      rf_wdata_o  = '0;
      if (id_we_i) begin
         rf_wr_src_o = RF_SRC_ID;
         rf_waddr_o  = id_waddr_i;
         rf_wdata_o  = id_wdata_i;
      end else if (lsu_we_i) begin
         rf_wr_src_o = RF_SRC_LSU;
         rf_waddr_o  = lsu_waddr_i;
         rf_wdata_o  = lsu_wdata_i;
      end else if (head_live) begin
         rf_wr_src_o = RF_SRC_PMC;
         rf_waddr_o  = head_addr;
         rf_wdata_o  = head_data;
      end
   end

   assign rf_we_o = (rf_wr_src_o != RF_SRC_NONE);

   always_ff @(posedge clk_i) begin
      if (rst_i) collision_err_o <= 1'b0;
      else if (id_we_i && lsu_we_i) collision_err_o <= 1'b1;
   end

`ifdef APMU_RF_ARB_STARVE_EN
   localparam int unsigned CntW = $clog2(MaxStall + 1);

   arb_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            drain;

   assign drain      = head_live && port_free;
   assign stall_id_o = (state_q == ARB_FORCE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (head_live && live_any_next) state_d = ARB_WAIT;
         end
         ARB_WAIT: begin
            if (!live_any_next) begin
               state_d = ARB_IDLE;
               cnt_d   = '0;
            end else if (drain) begin
               cnt_d   = '0;
            end else if (cnt_q == CntW'(MaxStall)) begin
               state_d = ARB_FORCE;
            end else if (head_live) begin
               cnt_d   = cnt_q + CntW'(1);
            end
         end
         ARB_FORCE: begin
            if (!live_any_next) begin
               state_d = ARB_IDLE;
               cnt_d   = '0;
            end else if (drain) begin
               state_d = ARB_WAIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   logic unused_live_any;
   assign unused_live_any = live_any_next;
   assign stall_id_o      = 1'b0;
`endif

   a_one_src: assert property (@(posedge clk_i) disable iff (rst_i)
      rf_we_o |-> $onehot({rf_wr_src_o == RF_SRC_ID, rf_wr_src_o == RF_SRC_LSU,
                           rf_wr_src_o == RF_SRC_PMC}));
   a_params: assert property (@(posedge clk_i) (MaxStall >= 1) && (FifoDepth >= 2));

endmodule

// File: tb/tb_apmu_ibex_rf_wr_arbiter.sv
// Self-checking bench for the RF write-port arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_apmu_ibex_rf_wr_arbiter;
   import apmu_ibex_pkg::*;

   localparam int unsigned Depth    = 2;
   localparam int unsigned MaxStall = 8;
   localparam int unsigned PendW    = $clog2(Depth) + 1;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              id_we_i, lsu_we_i, pmc_valid_i;
   logic [4:0]        id_waddr_i, lsu_waddr_i, pmc_waddr_i, rs1_addr_i, rs2_addr_i;
   logic [31:0]       id_wdata_i, lsu_wdata_i, pmc_wdata_i;
   logic              pmc_ready_o, rf_we_o, rd_hazard_o, stall_id_o, collision_err_o;
   logic [4:0]        rf_waddr_o;
   logic [31:0]       rf_wdata_o;
   rf_wr_src_e        rf_wr_src_o;
   logic [PendW-1:0]  pmc_pending_o;

   int n_checks = 0;
   int n_errors = 0;

   // Reference queue entries: {live, addr[4:0], data[31:0]}.
   logic [37:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   apmu_ibex_rf_wr_arbiter #(.FifoDepth(Depth), .MaxStall(MaxStall)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_we_i(id_we_i), .id_waddr_i(id_waddr_i), .id_wdata_i(id_wdata_i),
      .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
      .pmc_valid_i(pmc_valid_i), .pmc_ready_o(pmc_ready_o),
      .pmc_waddr_i(pmc_waddr_i), .pmc_wdata_i(pmc_wdata_i),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .rf_wr_src_o(rf_wr_src_o),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rd_hazard_o(rd_hazard_o), .stall_id_o(stall_id_o),
      .pmc_pending_o(pmc_pending_o), .collision_err_o(collision_err_o)
   );

   task automatic drive_idle();
      id_we_i = 0;  id_waddr_i = 0;  id_wdata_i = 0;
      lsu_we_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
      pmc_valid_i = 0; pmc_waddr_i = 0; pmc_wdata_i = 0;
      rs1_addr_i = 0; rs2_addr_i = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_id(input logic [4:0] a, input logic [31:0] d);
      id_we_i = 1; id_waddr_i = a; id_wdata_i = d;
   endtask

   task automatic drive_pmc(input logic [4:0] a, input logic [31:0] d);
      pmc_valid_i = 1; pmc_waddr_i = a; pmc_wdata_i = d;
   endtask

   task automatic test_reset();
      rst_i = 1;
      drive_idle();
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 0;
      #2;
      n_checks += 5;
      if (rf_we_o !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b want 0", rf_we_o); end
      if (pmc_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", pmc_ready_o); end
      if (stall_id_o !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", stall_id_o); end
      if (rd_hazard_o !== 1'b0) begin n_errors++; $display("FAIL reset_hazard: got %b want 0", rd_hazard_o); end
      if (pmc_pending_o !== '0) begin n_errors++; $display("FAIL reset_pending: got %0d want 0", pmc_pending_o); end
      next_cycle();
   endtask

   task automatic test_idle_write();
      drive_pmc(5'd5, 32'hA5);
      #2;
      n_checks += 2;
      if (rf_we_o !== 1'b0) begin n_errors++; $display("FAIL idle_no_bypass: got we=%b want 0", rf_we_o); end
      if (pmc_pending_o !== 0) begin n_errors++; $display("FAIL idle_pend0: got %0d want 0", pmc_pending_o); end
      next_cycle();
      pmc_valid_i = 0;
      #2;
      n_checks += 5;
      if (rf_we_o !== 1'b1) begin n_errors++; $display("FAIL idle_we: got %b want 1", rf_we_o); end
      if (rf_waddr_o !== 5'd5) begin n_errors++; $display("FAIL idle_waddr: got %0d want 5", rf_waddr_o); end
      if (rf_wdata_o !== 32'hA5) begin n_errors++; $display("FAIL idle_wdata: got %h want a5", rf_wdata_o); end
      if (rf_wr_src_o !== RF_SRC_PMC) begin n_errors++; $display("FAIL idle_src: got %0d want PMC", rf_wr_src_o); end
      if (pmc_pending_o !== 1) begin n_errors++; $display("FAIL idle_pend1: got %0d want 1", pmc_pending_o); end
      next_cycle();
      #2;
      n_checks += 2;
      if (pmc_pending_o !== 0) begin n_errors++; $display("FAIL idle_pend_after: got %0d want 0", pmc_pending_o); end
      if (rf_we_o !== 1'b0) begin n_errors++; $display("FAIL idle_we_after: got %b want 0", rf_we_o); end
      next_cycle();
   endtask

   task automatic test_fill();
      drive_id(5'd1, 32'h100);
      drive_pmc(5'd2, 32'h22);
      #2;
      n_checks++;
      if (pmc_ready_o !== 1'b1) begin n_errors++; $display("FAIL fill_ready0: got %b want 1", pmc_ready_o); end
      next_cycle();
      drive_pmc(5'd3, 32'h33);
      #2;
      n_checks += 2;
      if (pmc_ready_o !== 1'b1) begin n_errors++; $display("FAIL fill_ready1: got %b want 1", pmc_ready_o); end
      if (rf_wr_src_o !== RF_SRC_ID) begin n_errors++; $display("FAIL fill_src_id: got %0d want ID", rf_wr_src_o); end
      next_cycle();
      drive_pmc(5'd4, 32'h44);
      for (int c = 2; c < 4; c++) begin
         #2;
         n_checks += 2;
         if (pmc_ready_o !== 1'b0) begin n_errors++; $display("FAIL fill_full_ready c%0d: got %b want 0", c, pmc_ready_o); end
         if (pmc_pending_o !== 2) begin n_errors++; $display("FAIL fill_full_pend c%0d: got %0d want 2", c, pmc_pending_o); end
         next_cycle();
      end
      id_we_i = 0;
      #2;
      n_checks += 3;
      if (rf_wr_src_o !== RF_SRC_PMC) begin n_errors++; $display("FAIL fill_drain1_src: got %0d want PMC", rf_wr_src_o); end
      if (rf_waddr_o !== 5'd2) begin n_errors++; $display("FAIL fill_drain1_addr: got %0d want 2", rf_waddr_o); end
      if (pmc_ready_o !== 1'b0) begin n_errors++; $display("FAIL fill_drain1_ready: got %b want 0", pmc_ready_o); end
      next_cycle();
      #2;
      n_checks += 2;
      if (pmc_ready_o !== 1'b1) begin n_errors++; $display("FAIL fill_third_ready: got %b want 1", pmc_ready_o); end
      if (rf_waddr_o !== 5'd3) begin n_errors++; $display("FAIL fill_drain2_addr: got %0d want 3", rf_waddr_o); end
      next_cycle();
      pmc_valid_i = 0;
      #2;
      n_checks += 3;
      if (rf_waddr_o !== 5'd4) begin n_errors++; $display("FAIL fill_drain3_addr: got %0d want 4", rf_waddr_o); end
      if (rf_wdata_o !== 32'h44) begin n_errors++; $display("FAIL fill_drain3_data: got %h want 44", rf_wdata_o); end
      if (pmc_pending_o !== 1) begin n_errors++; $display("FAIL fill_drain3_pend: got %0d want 1", pmc_pending_o); end
      next_cycle();
      #2;
      n_checks++;
      if (pmc_pending_o !== 0) begin n_errors++; $display("FAIL fill_empty: got %0d want 0", pmc_pending_o); end
      next_cycle();
   endtask

   task automatic test_squash();
      drive_id(5'd1, 32'h1);
      drive_pmc(5'd7, 32'h77);
      next_cycle();
      pmc_valid_i = 0;
      drive_id(5'd7, 32'h11);
      #2;
      n_checks += 3;
      if (rf_wr_src_o !== RF_SRC_ID) begin n_errors++; $display("FAIL squash_src: got %0d want ID", rf_wr_src_o); end
      if (rf_wdata_o !== 32'h11) begin n_errors++; $display("FAIL squash_data: got %h want 11", rf_wdata_o); end
      if (pmc_pending_o !== 1) begin n_errors++; $display("FAIL squash_pend1: got %0d want 1", pmc_pending_o); end
      next_cycle();
      id_we_i = 0;
      #2;
      n_checks++;
      if (rf_we_o !== 1'b0) begin n_errors++; $display("FAIL squash_no_pmc: got we=%b addr=%0d want 0", rf_we_o, rf_waddr_o); end
      next_cycle();
      #2;
      n_checks += 2;
      if (pmc_pending_o !== 0) begin n_errors++; $display("FAIL squash_pend0: got %0d want 0", pmc_pending_o); end
      if (rf_we_o !== 1'b0) begin n_errors++; $display("FAIL squash_we_late: got %b want 0", rf_we_o); end
      next_cycle();
   endtask

   task automatic test_hazard();
      drive_id(5'd1, 32'h1);
      drive_pmc(5'd3, 32'h3);
      next_cycle();
      pmc_valid_i = 0;
      rs2_addr_i = 5'd3;
      #2;
      n_checks++;
      if (rd_hazard_o !== 1'b1) begin n_errors++; $display("FAIL hazard_rs2: got %b want 1", rd_hazard_o); end
      rs2_addr_i = 0;
      #1;
      n_checks++;
      if (rd_hazard_o !== 1'b0) begin n_errors++; $display("FAIL hazard_zero: got %b want 0", rd_hazard_o); end
      rs1_addr_i = 5'd3;
      #1;
      n_checks++;
      if (rd_hazard_o !== 1'b1) begin n_errors++; $display("FAIL hazard_rs1: got %b want 1", rd_hazard_o); end
      next_cycle();
      id_we_i = 0;
      next_cycle();
      #2;
      n_checks++;
      if (rd_hazard_o !== 1'b0) begin n_errors++; $display("FAIL hazard_after_drain: got %b want 0", rd_hazard_o); end
      rs1_addr_i = 5'd9;
      drive_id(5'd1, 32'h1);
      drive_pmc(5'd9, 32'h9);
      #1;
      n_checks++;
      if (rd_hazard_o !== 1'b1) begin n_errors++; $display("FAIL hazard_incoming: got %b want 1", rd_hazard_o); end
      next_cycle();
      drive_idle();
      next_cycle();
   endtask

   task automatic test_starvation();
`ifdef APMU_RF_ARB_STARVE_EN
      // Head is live from cycle 1, WAIT entered in cycle 2, the counter shows
      // MaxStall in cycle 2+MaxStall, and stall_id_o rises one cycle later.
      drive_id(5'd1, 32'h1);
      drive_pmc(5'd6, 32'h66);
      for (int c = 0; c <= MaxStall + 3; c++) begin
         #2;
         n_checks++;
         if (stall_id_o !== (c >= MaxStall + 3)) begin
            n_errors++; $display("FAIL starve_stall c%0d: got %b want %b", c, stall_id_o, c >= MaxStall + 3);
         end
         next_cycle();
         pmc_valid_i = 0;
      end
      id_we_i = 0;
      #2;
      n_checks += 3;
      if (rf_wr_src_o !== RF_SRC_PMC) begin n_errors++; $display("FAIL starve_drain_src: got %0d want PMC", rf_wr_src_o); end
      if (rf_waddr_o !== 5'd6) begin n_errors++; $display("FAIL starve_drain_addr: got %0d want 6", rf_waddr_o); end
      if (stall_id_o !== 1'b1) begin n_errors++; $display("FAIL starve_hold: got %b want 1", stall_id_o); end
      next_cycle();
      #2;
      n_checks += 2;
      if (stall_id_o !== 1'b0) begin n_errors++; $display("FAIL starve_release: got %b want 0", stall_id_o); end
      if (pmc_pending_o !== 0) begin n_errors++; $display("FAIL starve_pend: got %0d want 0", pmc_pending_o); end
      next_cycle();
`else
      drive_id(5'd1, 32'h1);
      drive_pmc(5'd6, 32'h66);
      for (int c = 0; c < 20; c++) begin
         #2;
         n_checks++;
         if (stall_id_o !== 1'b0) begin n_errors++; $display("FAIL nostarve_stall c%0d: got %b want 0", c, stall_id_o); end
         next_cycle();
         pmc_valid_i = 0;
      end
      #2;
      n_checks++;
      if (pmc_pending_o !== 1) begin n_errors++; $display("FAIL nostarve_pend: got %0d want 1", pmc_pending_o); end
      id_we_i = 0;
      #1;
      n_checks++;
      if (rf_waddr_o !== 5'd6) begin n_errors++; $display("FAIL nostarve_drain: got %0d want 6", rf_waddr_o); end
      next_cycle();
`endif
   endtask

   task automatic test_collision_reset();
      drive_id(5'd1, 32'h1);
      lsu_we_i = 1; lsu_waddr_i = 5'd2; lsu_wdata_i = 32'h2;
      drive_pmc(5'd8, 32'h88);
      #2;
      n_checks += 3;
      if (rf_wr_src_o !== RF_SRC_ID) begin n_errors++; $display("FAIL coll_src: got %0d want ID", rf_wr_src_o); end
      if (rf_waddr_o !== 5'd1) begin n_errors++; $display("FAIL coll_addr: got %0d want 1", rf_waddr_o); end
      if (collision_err_o !== 1'b0) begin n_errors++; $display("FAIL coll_early: got %b want 0", collision_err_o); end
      next_cycle();
      lsu_we_i = 0;
      pmc_valid_i = 0;
      #2;
      n_checks += 2;
      if (collision_err_o !== 1'b1) begin n_errors++; $display("FAIL coll_set: got %b want 1", collision_err_o); end
      if (pmc_pending_o !== 1) begin n_errors++; $display("FAIL coll_pend: got %0d want 1", pmc_pending_o); end
      next_cycle();
      #2;
      n_checks++;
      if (collision_err_o !== 1'b1) begin n_errors++; $display("FAIL coll_sticky: got %b want 1", collision_err_o); end
      rst_i = 1;
      next_cycle();
      rst_i = 0;
      drive_idle();
      rs1_addr_i = 5'd8;
      #2;
      n_checks += 6;
      if (rf_we_o !== 1'b0) begin n_errors++; $display("FAIL rst_we: got %b want 0", rf_we_o); end
      if (pmc_ready_o !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b want 1", pmc_ready_o); end
      if (stall_id_o !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b want 0", stall_id_o); end
      if (rd_hazard_o !== 1'b0) begin n_errors++; $display("FAIL rst_hazard: got %b want 0", rd_hazard_o); end
      if (pmc_pending_o !== 0) begin n_errors++; $display("FAIL rst_pend: got %0d want 0", pmc_pending_o); end
      if (collision_err_o !== 1'b0) begin n_errors++; $display("FAIL rst_coll: got %b want 0", collision_err_o); end
      next_cycle();
      #2;
      n_checks++;
      if (rf_we_o !== 1'b0) begin n_errors++; $display("FAIL rst_discard: got we=%b want 0", rf_we_o); end
      next_cycle();
   endtask

   task automatic test_random();
      logic        e_we, e_ready, e_haz, e_coll, acc, pop;
      logic [4:0]  e_a, g;
      logic [31:0] e_d;
      rf_wr_src_e  e_src;
      exp_q.delete();
      e_coll = 0;
      for (int c = 0; c < 400; c++) begin
         id_we_i     = ($urandom_range(0, 99) < 40);
         id_waddr_i  = 5'($urandom_range(0, 7));
         id_wdata_i  = $urandom;
         lsu_we_i    = ($urandom_range(0, 99) < 15);
         lsu_waddr_i = 5'($urandom_range(0, 7));
         lsu_wdata_i = $urandom;
         pmc_valid_i = ($urandom_range(0, 99) < 60);
         pmc_waddr_i = 5'($urandom_range(0, 7));
         pmc_wdata_i = $urandom;
         rs1_addr_i  = 5'($urandom_range(0, 7));
         rs2_addr_i  = 5'($urandom_range(0, 7));
         #2;
         // Reference: fixed priority, head only when live, queue bounded by Depth.
         e_src = RF_SRC_NONE; e_a = 0; e_d = 0;
         if (id_we_i) begin e_src = RF_SRC_ID; e_a = id_waddr_i; e_d = id_wdata_i; end
         else if (lsu_we_i) begin e_src = RF_SRC_LSU; e_a = lsu_waddr_i; e_d = lsu_wdata_i; end
         else if (exp_q.size() > 0 && exp_q[0][37]) begin
            e_src = RF_SRC_PMC; e_a = exp_q[0][36:32]; e_d = exp_q[0][31:0];
         end
         e_we    = (e_src != RF_SRC_NONE);
         e_ready = (exp_q.size() < Depth);
         acc     = pmc_valid_i && e_ready && (pmc_waddr_i != 0);
         e_haz   = acc && ((pmc_waddr_i == rs1_addr_i) || (pmc_waddr_i == rs2_addr_i));
         foreach (exp_q[i]) begin
            if (exp_q[i][37] && ((exp_q[i][36:32] == rs1_addr_i) || (exp_q[i][36:32] == rs2_addr_i))) e_haz = 1;
         end
         n_checks += 6;
         if (rf_we_o !== e_we) begin n_errors++; $display("FAIL rnd_we c%0d: got %b want %b", c, rf_we_o, e_we); end
         if (rf_wr_src_o !== e_src) begin n_errors++; $display("FAIL rnd_src c%0d: got %0d want %0d", c, rf_wr_src_o, e_src); end
         if (pmc_ready_o !== e_ready) begin n_errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, pmc_ready_o, e_ready); end
         if (pmc_pending_o !== PendW'(exp_q.size())) begin n_errors++; $display("FAIL rnd_pend c%0d: got %0d want %0d", c, pmc_pending_o, exp_q.size()); end
         if (rd_hazard_o !== e_haz) begin n_errors++; $display("FAIL rnd_hazard c%0d: got %b want %b", c, rd_hazard_o, e_haz); end
         if (collision_err_o !== e_coll) begin n_errors++; $display("FAIL rnd_coll c%0d: got %b want %b", c, collision_err_o, e_coll); end
         if (e_we) begin
            n_checks += 2;
            if (rf_waddr_o !== e_a) begin n_errors++; $display("FAIL rnd_waddr c%0d: got %0d want %0d", c, rf_waddr_o, e_a); end
            if (rf_wdata_o !== e_d) begin n_errors++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, rf_wdata_o, e_d); end
         end
`ifndef APMU_RF_ARB_STARVE_EN
         n_checks++;
         if (stall_id_o !== 1'b0) begin n_errors++; $display("FAIL rnd_stall c%0d: got %b want 0", c, stall_id_o); end
`endif
         pop = (exp_q.size() > 0) && (!exp_q[0][37] || (!id_we_i && !lsu_we_i));
         if (id_we_i || lsu_we_i) begin
            g = id_we_i ? id_waddr_i : lsu_waddr_i;
            foreach (exp_q[i]) if (exp_q[i][37] && exp_q[i][36:32] == g) exp_q[i][37] = 1'b0;
         end
         if (pop) void'(exp_q.pop_front());
         if (acc) exp_q.push_back({1'b1, pmc_waddr_i, pmc_wdata_i});
         if (id_we_i && lsu_we_i) e_coll = 1;
         next_cycle();
      end
      drive_idle();
   endtask

   initial begin
      rst_i = 1;
      drive_idle();
      test_reset();
      test_idle_write();
      test_fill();
      test_squash();
      test_hazard();
      test_starvation();
      test_collision_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
